// File: rtl/cpu_controller_pkg.sv
// cpu_pkg: shared encodings for the CPU controller.
//   state_t  : controller FSM states, one cycle each.
//   iclass_t : instruction class derived from opcode/op.
//   opcode/op, vsel and ALUop encodings, plus classify() used by the
//   FSM (on the word about to be decoded) and by the decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT      = 3'd0,
    DECODE    = 3'd1,
    GET_A     = 3'd2,
    GET_B     = 3'd3,
    ALU       = 3'd4,
    WRITE_RD  = 3'd5,
    WRITE_IMM = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    IC_BAD     = 3'd0,
    IC_MOV_IMM = 3'd1,
    IC_MOV_REG = 3'd2,
    IC_ADD     = 3'd3,
    IC_CMP     = 3'd4,
    IC_AND     = 3'd5,
    IC_MVN     = 3'd6
  } iclass_t;

  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [2:0] OPC_MOV    = 3'b110;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_AND    = 2'b10;
  localparam logic [1:0] ALU_NOTB   = 2'b11;

  // Map the opcode/op pair of an instruction word onto its class.
  function automatic iclass_t classify(input logic [15:0] ir);
    iclass_t c;
    c = IC_BAD;
    case (ir[15:11])
      {OPC_MOV, OP_MOV_IMM}: c = IC_MOV_IMM;
      {OPC_MOV, OP_MOV_REG}: c = IC_MOV_REG;
      {OPC_ALU, OP_ADD}:     c = IC_ADD;
      {OPC_ALU, OP_CMP}:     c = IC_CMP;
      {OPC_ALU, OP_AND}:     c = IC_AND;
      {OPC_ALU, OP_MVN}:     c = IC_MVN;
      default:               c = IC_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: purely combinational view of the instruction register.
//   i_ir        : instruction register contents
//   i_read_rn   : 1 = readnum selects Rn (GET_A), else Rm
//   i_write_rn  : 1 = writenum selects Rn (WRITE_IMM), else Rd
//   o_readnum / o_writenum : register-file addresses
//   o_sximm8 / o_sximm5    : sign-extended IR[7:0] / IR[4:0]
//   o_aluop, o_asel, o_bsel, o_shift : decoded datapath levels
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [15:0]   i_ir,
  input  logic          i_read_rn,
  input  logic          i_write_rn,
  output logic [RW-1:0] o_readnum,
  output logic [RW-1:0] o_writenum,
  output logic [DW-1:0] o_sximm8,
  output logic [DW-1:0] o_sximm5,
  output logic [1:0]    o_aluop,
  output logic          o_asel,
  output logic          o_bsel,
  output logic [1:0]    o_shift
);

  logic [2:0]    w_opcode;
  logic [1:0]    w_op;
  logic [RW-1:0] w_rn;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rm;
  logic [1:0]    w_sh;
  iclass_t       w_iclass;

  assign w_opcode = i_ir[15:13];
  assign w_op     = i_ir[12:11];
  assign w_rn     = i_ir[10:8];
  assign w_rd     = i_ir[7:5];
  assign w_sh     = i_ir[4:3];
  assign w_rm     = i_ir[2:0];
  assign w_iclass = classify(i_ir);

  assign o_sximm8   = {{(DW-8){i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5   = {{(DW-5){i_ir[4]}}, i_ir[4:0]};

  assign o_readnum  = i_read_rn  ? w_rn : w_rm;
  assign o_writenum = i_write_rn ? w_rn : w_rd;

  // ALU ops carry their operation in op; MOV forms pass B through an add.
  assign o_aluop = (w_opcode == OPC_ALU) ? w_op : ALU_ADD;
  // MOV reg and MVN only use B, so A is forced to zero.
  assign o_asel  = (w_iclass == IC_MOV_REG) || (w_iclass == IC_MVN);
  assign o_bsel  = 1'b0;
  // The immediate form reuses IR[4:3] as immediate bits, not a shift.
  assign o_shift = (w_iclass == IC_MOV_IMM) ? 2'b00 : w_sh;

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore FSM that sequences the
// datapath strobes for one instruction at a time.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in, load, s          : host instruction word, IR capture, start
//   w                    : 1 = idle in WAIT
//   bad                  : one-cycle pulse in DECODE for unsupported words
//   readnum, writenum    : register-file addresses
//   write, loada/b/c/s   : register strobes
//   asel, bsel, vsel     : operand / writeback selects
//   ALUop, shift         : ALU and shifter control
//   sximm8, sximm5       : sign-extended immediates
//
// Host handshake: w acts as ready. load and s are sampled only on a clock
// edge where w=1 (state WAIT); both may be high together, in which case the
// new word is captured and decoded. Once started, w stays low until the
// instruction finishes; load/s during that time are ignored. Holding s high
// as w returns starts the next instruction on the following edge.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic          bad,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    vsel,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5
);

  state_t      r_state;
  logic [15:0] r_ir;
  logic        r_w;
  logic        r_bad;
  logic        r_write;
  logic        r_loada;
  logic        r_loadb;
  logic        r_loadc;
  logic        r_loads;
  logic [1:0]  r_vsel;

  state_t      w_state_nxt;
  logic [15:0] w_ir_nxt;
  iclass_t     w_iclass_nxt;

  // The word DECODE will look at: a load in WAIT takes effect on the same
  // edge that starts the instruction.
  assign w_ir_nxt     = ((r_state == WAIT) && load) ? in : r_ir;
  assign w_iclass_nxt = classify(w_ir_nxt);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT:   if (s) w_state_nxt = DECODE;
      DECODE: begin
        case (w_iclass_nxt)
          IC_MOV_IMM:                 w_state_nxt = WRITE_IMM;
          IC_MOV_REG, IC_MVN:         w_state_nxt = GET_B;
          IC_ADD, IC_AND, IC_CMP:     w_state_nxt = GET_A;
          default:                    w_state_nxt = WAIT;
        endcase
      end
      GET_A:     w_state_nxt = GET_B;
      GET_B:     w_state_nxt = ALU;
      ALU:       w_state_nxt = (w_iclass_nxt == IC_CMP) ? WAIT : WRITE_RD;
      WRITE_RD:  w_state_nxt = WAIT;
      WRITE_IMM: w_state_nxt = WAIT;
      default:   w_state_nxt = WAIT;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly
  // with the state they belong to and drop at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
      r_ir    <= '0;
      r_w     <= 1'b1;
      r_bad   <= 1'b0;
      r_write <= 1'b0;
      r_loada <= 1'b0;
      r_loadb <= 1'b0;
      r_loadc <= 1'b0;
      r_loads <= 1'b0;
      r_vsel  <= VSEL_C;
    end else begin
      r_state <= w_state_nxt;
      r_ir    <= w_ir_nxt;
      r_w     <= (w_state_nxt == WAIT);
      r_bad   <= (w_state_nxt == DECODE) && (w_iclass_nxt == IC_BAD);
      r_loada <= (w_state_nxt == GET_A);
      r_loadb <= (w_state_nxt == GET_B);
      r_loadc <= (w_state_nxt == ALU);
      r_loads <= (w_state_nxt == ALU) && (w_ir_nxt[15:13] == OPC_ALU);
      r_write <= (w_state_nxt == WRITE_RD) || (w_state_nxt == WRITE_IMM);
      r_vsel  <= (w_state_nxt == WRITE_IMM) ? VSEL_IMM8 : VSEL_C;
    end
  end

  assign w     = r_w;
  assign bad   = r_bad;
  assign write = r_write;
  assign loada = r_loada;
  assign loadb = r_loadb;
  assign loadc = r_loadc;
  assign loads = r_loads;
  assign vsel  = r_vsel;

  instr_decoder #(
    .DW (DW),
    .RW (RW)
  ) u_decoder (
    .i_ir       (r_ir),
    .i_read_rn  (r_state == GET_A),
    .i_write_rn (r_state == WRITE_IMM),
    .o_readnum  (readnum),
    .o_writenum (writenum),
    .o_sximm8   (sximm8),
    .o_sximm5   (sximm5),
    .o_aluop    (ALUop),
    .o_asel     (asel),
    .o_bsel     (bsel),
    .o_shift    (shift)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: drives instructions through the host
// handshake, runs a small behavioural datapath (mdata=0, PC=0) off the
// controller strobes, and checks per-instruction results against an
// instruction-level reference model via an expected queue.
module tb_cpu_controller;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [15:0] in;
  logic        load, s;
  logic        w, bad, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, ALUop, shift;
  logic [15:0] sximm8, sximm5;

  cpu_controller #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .load(load), .s(s),
    .w(w), .bad(bad), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
    .ALUop(ALUop), .shift(shift), .sximm8(sximm8), .sximm5(sximm5)
  );

  // ---------------- datapath model ----------------
  logic [15:0] rf [8];
  logic [15:0] ra = '0, rb = '0, rc = '0;
  logic [2:0]  st = '0;   // {Z, N, V}
  logic [15:0] b_sh, a_in, b_in, alu_y, wb_data;
  logic        alu_v;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b00:   return v;
      2'b01:   return {v[14:0], 1'b0};
      2'b10:   return {1'b0, v[15:1]};
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  always_comb begin
    b_sh  = shf(rb, shift);
    a_in  = asel ? 16'h0 : ra;
    b_in  = bsel ? sximm5 : b_sh;
    alu_v = 1'b0;
    alu_y = '0;
    case (ALUop)
      2'b00: begin
        alu_y = a_in + b_in;
        alu_v = (a_in[15] == b_in[15]) && (alu_y[15] != a_in[15]);
      end
      2'b01: begin
        alu_y = a_in - b_in;
        alu_v = (a_in[15] != b_in[15]) && (alu_y[15] != a_in[15]);
      end
      2'b10:   alu_y = a_in & b_in;
      default: alu_y = ~b_in;
    endcase
    case (vsel)
      2'b00:   wb_data = 16'h0000;
      2'b01:   wb_data = sximm8;
      2'b10:   wb_data = 16'h0000;
      default: wb_data = rc;
    endcase
  end

  always @(posedge clk) begin
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu_y;
    if (loads) st <= {alu_y == 16'h0, alu_y[15], alu_v};
    if (write) rf[writenum] <= wb_data;
  end

  // ---------------- monitor (free-running counters) ----------------
  int          m_busy = 0, m_wr = 0, m_bad = 0, m_ld = 0, m_loads = 0;
  logic [2:0]  m_wnum = '0;
  logic [15:0] m_wval = '0;

  always @(negedge clk) begin
    if (!w) m_busy++;
    if (write) begin
      m_wr++;
      m_wnum = writenum;
      m_wval = wb_data;
    end
    if (bad) m_bad++;
    if (loada | loadb | loadc) m_ld++;
    if (loads) m_loads++;
  end

  // ---------------- scoreboard ----------------
  // Expected word: [31:28] busy cycles, [27] bad, [26] write, [25:23] reg,
  // [22:7] value, [6] loads, [5:3] status {Z,N,V}, [2:0] A/B/C load cycles.
  logic [W-1:0] exp_q[$];
  logic [15:0]  ref_r [8];
  logic [2:0]   ref_st = '0;
  int           n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [15:0] ir, output logic [W-1:0] e);
    logic [2:0]  opc, rn, rd, rm, wreg, ldc;
    logic [1:0]  op, sh;
    logic [15:0] a, b, y, wval;
    logic [3:0]  busy;
    logic        v, bd, wr, ls;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    busy = 4'd1; bd = 1'b1; wr = 1'b0; wreg = '0; wval = '0; ls = 1'b0; ldc = '0;
    b = shf(ref_r[rm], sh);
    if (opc == 3'b110 && op == 2'b10) begin
      busy = 4'd2; bd = 1'b0; wr = 1'b1; wreg = rn; wval = {{8{ir[7]}}, ir[7:0]};
    end else if (opc == 3'b110 && op == 2'b00) begin
      busy = 4'd4; bd = 1'b0; wr = 1'b1; wreg = rd; wval = b; ldc = 3'd2;
    end else if (opc == 3'b101) begin
      bd = 1'b0; ls = 1'b1; v = 1'b0;
      a = (op == 2'b11) ? 16'h0 : ref_r[rn];
      case (op)
        2'b00: begin y = a + b; v = (a[15] == b[15]) && (y[15] != a[15]); end
        2'b01: begin y = a - b; v = (a[15] != b[15]) && (y[15] != a[15]); end
        2'b10: y = a & b;
        default: y = ~b;
      endcase
      ref_st = {y == 16'h0, y[15], v};
      if (op == 2'b01) begin
        busy = 4'd4; ldc = 3'd3;
      end else begin
        busy = (op == 2'b11) ? 4'd4 : 4'd5;
        ldc  = (op == 2'b11) ? 3'd2 : 3'd3;
        wr = 1'b1; wreg = rd; wval = y;
      end
    end
    if (wr) ref_r[wreg] = wval;
    e = {busy, bd, wr, wreg, wval, ls, ref_st, ldc};
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT in WAIT; load+s go high immediately.
  // With noise set, load stays high with a different word while busy.
  task automatic run_instr(input logic [15:0] ir, input logic noise);
    logic [W-1:0] e;
    int b0, w0, bd0, l0, s0, cyc;
    logic [2:0] opc;
    logic [1:0] op;
    model(ir, e);
    exp_q.push_back(e);
    b0 = m_busy; w0 = m_wr; bd0 = m_bad; l0 = m_ld; s0 = m_loads;
    in = ir; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = noise; in = noise ? 16'h00F3 : ir; s = 1'b0;
    cyc = 0;
    while (!w && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    load = 1'b0;
    check("w_return", w, 1);
    e = exp_q.pop_front();
    check("busy",   m_busy - b0,  e[31:28]);
    check("bad",    m_bad - bd0,  e[27]);
    check("writes", m_wr - w0,    e[26]);
    if (e[26]) begin
      check("writenum_wr", m_wnum, e[25:23]);
      check("wdata",       m_wval, e[22:7]);
    end
    check("loads",  m_loads - s0, e[6]);
    check("status", st,           e[5:3]);
    check("ldcyc",  m_ld - l0,    e[2:0]);
    // Decoded levels in WAIT reflect the (unchanged) IR.
    check("sximm8",   sximm8,   {{8{ir[7]}}, ir[7:0]});
    check("sximm5",   sximm5,   {{11{ir[4]}}, ir[4:0]});
    check("readnum",  readnum,  ir[2:0]);
    check("writenum", writenum, ir[7:5]);
    check("bsel",     bsel,     0);
    opc = ir[15:13]; op = ir[12:11];
    if (!e[27]) begin
      check("aluop", ALUop, (opc == 3'b101) ? op : 2'b00);
      check("asel",  asel,  (opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11));
      check("shift", shift, (opc == 3'b110 && op == 2'b10) ? 2'b00 : ir[4:3]);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    logic [15:0] ir;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    logic [7:0]  imm;
    int          t, cyc;
    in = '0; load = 1'b0; s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf[i] = '0;
      ref_r[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_w", w, 1);
    check("rst_bad", bad, 0);
    check("rst_write", write, 0);
    check("rst_loada", loada, 0);
    check("rst_loadb", loadb, 0);
    check("rst_loadc", loadc, 0);
    check("rst_loads", loads, 0);
    check("rst_vsel", vsel, 2'b11);
    check("rst_readnum", readnum, 0);
    check("rst_sximm8", sximm8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence
    run_instr(16'hD005, 1'b0);
    run_instr(16'hD107, 1'b0);
    check("R0_lit", rf[0], 16'd5);
    check("R1_lit", rf[1], 16'd7);
    run_instr(16'hA041, 1'b1);
    check("R2_lit", rf[2], 16'd12);
    check("st_add_lit", st, 3'b000);
    run_instr(16'hA801, 1'b0);
    check("st_cmp_lit", st, 3'b010);
    run_instr(16'hC069, 1'b0);
    check("R3_lit", rf[3], 16'd14);
    run_instr(16'hB880, 1'b0);
    check("R4_lit", rf[4], 16'hFFFA);
    run_instr(16'hD5FE, 1'b0);
    check("R5_lit", rf[5], 16'hFFFE);
    run_instr(16'hE000, 1'b1);
    run_instr(16'hD805, 1'b0);
    run_instr(16'h0000, 1'b1);

    // Random supported instructions
    for (int k = 0; k < 16; k++) begin
      t   = $urandom_range(0, 5);
      rn  = 3'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      rm  = 3'($urandom_range(0, 7));
      sh  = 2'($urandom_range(0, 3));
      imm = 8'($urandom_range(0, 255));
      case (t)
        0:       ir = {3'b110, 2'b10, rn, imm};
        1:       ir = {3'b110, 2'b00, 3'b000, rd, sh, rm};
        2:       ir = {3'b101, 2'b00, rn, rd, sh, rm};
        3:       ir = {3'b101, 2'b01, rn, 3'b000, sh, rm};
        4:       ir = {3'b101, 2'b10, rn, rd, sh, rm};
        default: ir = {3'b101, 2'b11, 3'b000, rd, sh, rm};
      endcase
      run_instr(ir, 1'($urandom_range(0, 1)));
    end

    // Reset in GET_B of an ADD: strobes drop at once, IR cleared, no write.
    in = 16'hA041; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    cyc = 0;
    while (!loadb && cyc < 5) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst_in_getb", loadb, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_w", w, 1);
    check("midrst_loadb", loadb, 0);
    check("midrst_write", write, 0);
    check("midrst_sximm8", sximm8, 0);
    check("midrst_readnum", readnum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_R2", rf[2], ref_r[2]);
    check("midrst_idle", w, 1);

    for (int i = 0; i < 8; i++) check($sformatf("rf%0d", i), rf[i], ref_r[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
